// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_REQ     = 3'd0,
        ST_WAIT    = 3'd1,
        ST_PRESENT = 3'd2,
        ST_DROP    = 3'd3,
        ST_HALTED  = 3'd4
    } fetch_state_t;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]  HALT_OPC  = 5'b00000;
    localparam logic [15:0] PC_INC    = 16'd2;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:11] == HALT_OPC;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Architectural PC register: redirect load beats increment, increment beats hold.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [15:0] load_pc_i,
    input  logic        inc_i,
    output logic [15:0] pc_o
);

    logic [15:0] pc_q;
    logic [15:0] pc_d;

    // next-PC selection
    always_comb begin
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (inc_i) begin
            pc_d = pc_q + PC_INC;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller feeding the IF_ID latch.
// Optional build macro FETCH_ALIGN_CHK_EN: odd redirect targets raise err and halt.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic        imem_stall,
    input  logic        imem_done,
    input  logic [15:0] imem_data,
    input  logic        stall_in,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr_out,
    output logic [15:0] pc_next_out,
    output logic        valid_out,
    output logic        err
);

    fetch_state_t state_q;
    logic [15:0]  instr_q;
    logic [15:0]  pc_next_q;
    logic         valid_q;
    logic         err_q;
    logic [15:0]  pc_cur;
    logic [15:0]  load_pc;
    logic         bad_redirect;
    logic         pc_load;
    logic         pc_inc;

`ifdef FETCH_ALIGN_CHK_EN
    assign bad_redirect = redirect & redirect_pc[0];
    assign load_pc      = redirect_pc;
`else
    assign bad_redirect = 1'b0;
    assign load_pc      = {redirect_pc[15:1], 1'b0};
`endif

    assign pc_load = redirect & ~bad_redirect;
    assign pc_inc  = (state_q == ST_WAIT) & imem_done & ~redirect;

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (pc_load),
        .load_pc_i (load_pc),
        .inc_i     (pc_inc),
        .pc_o      (pc_cur)
    );

    // fetch sequencing FSM with registered IF_ID-facing outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_REQ;
            instr_q   <= NOP_INSTR;
            pc_next_q <= 16'h0000;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else if (redirect) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            if (bad_redirect) begin
                err_q   <= 1'b1;
                state_q <= ST_HALTED;
            end else begin
                // an outstanding read must still drain; a same-cycle done completes it
                case (state_q)
                    ST_WAIT: state_q <= imem_done ? ST_REQ : ST_DROP;
                    ST_DROP: state_q <= imem_done ? ST_REQ : ST_DROP;
                    default: state_q <= ST_REQ;
                endcase
            end
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (!imem_stall) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_done) begin
                        instr_q   <= imem_data;
                        pc_next_q <= pc_cur + PC_INC;
                        valid_q   <= 1'b1;
                        state_q   <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (!stall_in) begin
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                        state_q <= is_halt(instr_q) ? ST_HALTED : ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_done) begin
                        state_q <= ST_REQ;
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q <= ST_REQ;
                end
            endcase
        end
    end

    assign imem_rd     = (state_q == ST_REQ);
    assign imem_addr   = pc_cur;
    assign instr_out   = instr_q;
    assign pc_next_out = pc_next_q;
    assign valid_out   = valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl with a transaction-level fetch model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic        imem_stall;
    logic        imem_done;
    logic [15:0] imem_data;
    logic        stall_in;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr_out;
    logic [15:0] pc_next_out;
    logic        valid_out;
    logic        err;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_stall  (imem_stall),
        .imem_done   (imem_done),
        .imem_data   (imem_data),
        .stall_in    (stall_in),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_out   (instr_out),
        .pc_next_out (pc_next_out),
        .valid_out   (valid_out),
        .err         (err)
    );

    logic [15:0] mem [0:255];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // memory-side model
    bit          pend;
    int          pend_cnt;
    logic [15:0] pend_addr;

    // architectural fetch model
    logic [15:0] m_pc;
    logic [15:0] m_infl;
    logic [15:0] m_cur;
    bit          m_live;
    bit          m_pres;
    bit          m_halted;
    bit          m_err;
    int          idle;
    bit          abort;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    // one cycle of stimulus plus the model's view of the coming posedge
    task automatic step();
        logic [15:0] t;
        bit acc;
        bit consume;
        bit pushed;
        imem_done = 1'b0;
        imem_data = 16'($urandom_range(0, 65535));
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_done = 1'b1;
                imem_data = mem[pend_addr[8:1]];
                pend      = 1'b0;
            end
        end
        stall_in = ($urandom_range(0, 3) == 0);
        redirect = ($urandom_range(0, m_halted ? 6 : 29) == 0);
        case ($urandom_range(0, 5))
            0: t = 16'hFFFE;
            1: t = 16'h0040;
            2: t = 16'h0010;
            default: t = 16'($urandom_range(0, 65535)) & 16'hFFFE;
        endcase
        if (!pend && $urandom_range(0, 4) == 0) t[0] = 1'b1;
        redirect_pc = t;
        imem_stall  = ($urandom_range(0, 3) == 0) || (redirect && imem_rd);

        check("err", {15'b0, err}, {15'b0, m_err});
        if (m_halted) check("halted_no_rd", {15'b0, imem_rd}, 16'd0);

        consume = m_pres && !stall_in;
        pushed  = 1'b0;
        if (imem_done && m_live && !redirect) begin
            m_cur = mem[m_infl[8:1]];
            exp_q.push_back({m_cur, m_infl + 16'd2});
            m_pc   = m_infl + 16'd2;
            pushed = 1'b1;
        end
        if (imem_done) m_live = 1'b0;

        acc = imem_rd && !imem_stall;
        if (acc) begin
            check("imem_addr", imem_addr, m_pc);
            pend      = 1'b1;
            pend_cnt  = $urandom_range(1, 3);
            pend_addr = imem_addr;
            m_live    = 1'b1;
            m_infl    = m_pc;
        end

        if (redirect) begin
            if (m_pres && stall_in) void'(exp_q.pop_front());
            m_pres = 1'b0;
            m_live = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            if (t[0]) begin
                m_err    = 1'b1;
                m_halted = 1'b1;
            end else begin
                m_pc     = t;
                m_halted = 1'b0;
            end
`else
            m_pc     = t & 16'hFFFE;
            m_halted = 1'b0;
`endif
        end else if (consume) begin
            m_pres = 1'b0;
            if (m_cur[15:11] == 5'b00000) m_halted = 1'b1;
        end else if (pushed) begin
            m_pres = 1'b1;
        end

        if (acc || consume || m_halted) idle = 0;
        else idle++;
        if (idle > 60) begin
            check("liveness_timeout", 16'(idle), 16'd0);
            abort = 1'b1;
        end
    endtask

    // scoreboard monitor: pops an expectation whenever IF_ID captures
    always @(negedge clk) begin
        logic [31:0] e;
        #1;
        if (!rst) begin
            if (valid_out && !stall_in) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {15'b0, valid_out}, 16'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_out", instr_out, e[31:16]);
                    check("pc_next_out", pc_next_out, e[15:0]);
                end
            end else if (!valid_out) begin
                check("nop_when_invalid", instr_out, 16'h0800);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 11) == 0) mem[i][15:11] = 5'b00000;
            else if (mem[i][15:11] == 5'b00000) mem[i][15:11] = 5'b11000;
        end
        rst = 1'b1; imem_stall = 1'b0; imem_done = 1'b0; imem_data = 16'h0000;
        stall_in = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        pend = 1'b0; pend_cnt = 0; pend_addr = 16'h0000;
        m_pc = 16'h0000; m_infl = 16'h0000; m_cur = 16'h0800;
        m_live = 1'b0; m_pres = 1'b0; m_halted = 1'b0; m_err = 1'b0;
        idle = 0; abort = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_valid", {15'b0, valid_out}, 16'd0);
        check("rst_instr", instr_out, 16'h0800);
        check("rst_pc_next", pc_next_out, 16'h0000);
        check("rst_err", {15'b0, err}, 16'd0);
        check("rst_rd", {15'b0, imem_rd}, 16'd1);
        check("rst_addr", imem_addr, 16'h0000);
        step();
        for (int c = 0; c < 3000 && !abort; c++) begin
            @(negedge clk);
            step();
        end

        // steer into WAIT at 0x0020, then reset mid-read
        for (int k = 0; k < 60 && !abort; k++) begin
            @(negedge clk);
            imem_done = 1'b0;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_done = 1'b1;
                    imem_data = mem[pend_addr[8:1]];
                    pend      = 1'b0;
                end
            end
            stall_in    = 1'b0;
            redirect    = (k == 0);
            redirect_pc = 16'h0020;
            imem_stall  = (k == 0);
            if (k > 0 && imem_rd && !pend) begin
                check("redirect_addr", imem_addr, 16'h0020);
                break;
            end
            if (k == 59) check("steer_timeout", 16'(k), 16'd0);
        end
        @(negedge clk);
        rst = 1'b1; imem_done = 1'b0; imem_stall = 1'b0; pend = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("wait_rst_rd", {15'b0, imem_rd}, 16'd1);
        check("wait_rst_addr", imem_addr, 16'h0000);
        check("wait_rst_valid", {15'b0, valid_out}, 16'd0);
        check("wait_rst_err", {15'b0, err}, 16'd0);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
